// File: rtl/spi_slave_cfg.sv
// Configurable SPI slave: CPOL/CPHA, bit order and word size, buffered TX with valid/ready, held RX word.
// Define SPI_SLAVE_CFG_SYNC_EN to pass i_sck, i_sce and i_sin through 2-flop synchronizers.
module spi_slave_cfg #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned WORD_BITS = $clog2(WORD_SIZE),
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sck,
  input  logic                 i_sce,
  input  logic                 i_sin,
  output logic                 o_sout,
  output logic                 o_sout_oe,
  input  logic [WORD_SIZE-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_underrun,
  output logic [WORD_SIZE-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ack,
  output logic                 o_rx_overrun,
  output logic                 o_busy
);
  localparam logic                 IDLE_LVL        = 1'(CPOL);
  localparam logic                 SAMPLE_ON_TRAIL = 1'(CPHA);
  localparam logic                 MSB_OUT         = 1'(MSB_FIRST);
  localparam logic [WORD_BITS-1:0] LAST_BIT        = WORD_BITS'(WORD_SIZE - 1);

  logic [2:0] pin_s;  // {sck, sce, sin} as seen by the core

`ifdef SPI_SLAVE_CFG_SYNC_EN
  logic [2:0] meta_q, meta_d, sync_q, sync_d;

  always_comb begin
    meta_d = {i_sck, i_sce, i_sin};
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= {IDLE_LVL, 1'b1, 1'b0};
      sync_q <= {IDLE_LVL, 1'b1, 1'b0};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign pin_s = sync_q;
`else
  assign pin_s = {i_sck, i_sce, i_sin};
`endif

  logic                 sck_q, sck_d, sck_dly_q, sck_dly_d;
  logic                 sel_q, sel_d, sel_dly_q, sel_dly_d;
  logic                 sin_q, sin_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic                 tx_ready_q, tx_ready_d, tx_udr_q, tx_udr_d;
  logic                 rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic                 sout_q, sout_d, busy_q, busy_d;

  logic                 lead, trail, sample, shift, last, load;
  logic [WORD_SIZE-1:0] rx_word;

  // Edge decode, TX holding/shift, RX assembly and word completion
  always_comb begin
    sck_d      = pin_s[2];
    sck_dly_d  = sck_q;
    sel_d      = ~pin_s[1];
    sel_dly_d  = sel_q;
    sin_d      = pin_s[0];
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_udr_d   = 1'b0;
    rx_ovr_d   = 1'b0;

    lead    = sel_q && (sck_q != IDLE_LVL) && (sck_dly_q == IDLE_LVL);
    trail   = sel_q && (sck_q == IDLE_LVL) && (sck_dly_q != IDLE_LVL);
    sample  = SAMPLE_ON_TRAIL ? trail : lead;
    shift   = SAMPLE_ON_TRAIL ? lead : trail;
    last    = (cnt_q == LAST_BIT);
    rx_word = MSB_OUT ? {rx_sh_q[WORD_SIZE-2:0], sin_q} : {sin_q, rx_sh_q[WORD_SIZE-1:1]};
    load    = SAMPLE_ON_TRAIL ? (shift && (cnt_q == '0))
                              : (sel_q && (!sel_dly_q || (sample && last)));

    if (!sel_q) begin
      cnt_d   = '0;
      rx_sh_d = '0;
      tx_sh_d = '0;
    end else begin
      if (load) begin
        tx_sh_d    = tx_ready_q ? '0 : hold_q;
        tx_udr_d   = tx_ready_q;
        tx_ready_d = 1'b1;
      end else if (shift && (cnt_q != '0)) begin
        tx_sh_d = MSB_OUT ? {tx_sh_q[WORD_SIZE-2:0], 1'b0} : {1'b0, tx_sh_q[WORD_SIZE-1:1]};
      end
      if (sample) begin
        rx_sh_d = rx_word;
        cnt_d   = last ? '0 : cnt_q + WORD_BITS'(1);
      end
    end

    // A completing word takes priority over a simultaneous acknowledge
    if (i_rx_ack) rx_valid_d = 1'b0;
    if (sample && last) begin
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
      rx_ovr_d   = rx_valid_q && !i_rx_ack;
    end

    // Accepted after any load this cycle, so it waits for the next word
    if (i_tx_valid && tx_ready_q) begin
      hold_d     = i_tx_data;
      tx_ready_d = 1'b0;
    end

    sout_d = sel_d && (MSB_OUT ? tx_sh_d[WORD_SIZE-1] : tx_sh_d[0]);
    busy_d = sel_d && (cnt_d != '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sck_q      <= IDLE_LVL;
      sck_dly_q  <= IDLE_LVL;
      sel_q      <= 1'b0;
      sel_dly_q  <= 1'b0;
      sin_q      <= 1'b0;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      tx_udr_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sck_q      <= sck_d;
      sck_dly_q  <= sck_dly_d;
      sel_q      <= sel_d;
      sel_dly_q  <= sel_dly_d;
      sin_q      <= sin_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      tx_udr_q   <= tx_udr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
    end
  end

  assign o_sout        = sout_q;
  assign o_sout_oe     = sel_q;
  assign o_tx_ready    = tx_ready_q;
  assign o_tx_underrun = tx_udr_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_rx_overrun  = rx_ovr_q;
  assign o_busy        = busy_q;

endmodule
